// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RST_FLUSH = 2'd0,
        RUN       = 2'd1,
        MEM_WAIT  = 2'd2
    } ctrl_state_e;

    // ALU operand source selects
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/forward_unit.sv
// Operand forwarding select for one Execute-stage source register.
// M-stage result wins over W-stage; x0 is never forwarded.
module forward_unit
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] RsE_i,
    input  logic [4:0] RdM_i,
    input  logic [4:0] RdW_i,
    input  logic       RegWriteM_i,
    input  logic       RegWriteW_i,
    output logic [1:0] Forward_o
);

    // Priority select: memory stage, then writeback, else register file
    always_comb begin
        Forward_o = FWD_RF;
        if (RegWriteM_i && (RdM_i != 5'd0) && (RdM_i == RsE_i)) begin
            Forward_o = FWD_MEM;
        end else if (RegWriteW_i && (RdW_i != 5'd0) && (RdW_i == RsE_i)) begin
            Forward_o = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Central stall/flush/forward controller for the 5-stage RV32I pipeline.
// Sequences a post-reset purge and multi-cycle data-memory waits.
module hazard_ctrl_unit
    import pipe_ctrl_pkg::*;
#(
    parameter int RESET_FLUSH_CYCLES = 2,
    parameter int MEM_TIMEOUT        = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] Rs1D_i,
    input  logic [4:0] Rs2D_i,
    input  logic [4:0] Rs1E_i,
    input  logic [4:0] Rs2E_i,
    input  logic [4:0] RdE_i,
    input  logic [4:0] RdM_i,
    input  logic [4:0] RdW_i,
    input  logic       RegWriteM_i,
    input  logic       RegWriteW_i,
    input  logic       ResultSrcE0_i,
    input  logic       PCSrcE_i,
    input  logic       DMemReqM_i,
    input  logic       DMemReadyM_i,
    output logic       StallF_o,
    output logic       StallD_o,
    output logic       StallE_o,
    output logic       StallM_o,
    output logic       FlushD_o,
    output logic       FlushE_o,
    output logic       FlushW_o,
    output logic [1:0] ForwardAE_o,
    output logic [1:0] ForwardBE_o,
    output logic       MemErr_o
);

    localparam int FCW = (RESET_FLUSH_CYCLES > 1) ? $clog2(RESET_FLUSH_CYCLES) : 1;
    localparam int TCW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [FCW-1:0] FLUSH_LOAD = FCW'(RESET_FLUSH_CYCLES - 1);
    localparam logic [TCW-1:0] TMO_MAX    = TCW'(MEM_TIMEOUT);

    ctrl_state_e    state_q, state_d;
    logic [FCW-1:0] flush_cnt_q, flush_cnt_d;
    logic [TCW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic [TCW-1:0] tmo_inc;
    logic           mem_err_q, mem_err_d;
    logic           lw_stall;

    // Load-use hazard; a taken branch kills the dependent instruction anyway
    always_comb begin
        lw_stall = ResultSrcE0_i && (RdE_i != 5'd0) &&
                   ((RdE_i == Rs1D_i) || (RdE_i == Rs2D_i)) && !PCSrcE_i;
        tmo_inc  = (tmo_cnt_q == TMO_MAX) ? tmo_cnt_q : tmo_cnt_q + TCW'(1);
    end

    // Next-state and Mealy stall/flush outputs
    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        tmo_cnt_d   = tmo_cnt_q;
        mem_err_d   = mem_err_q;
        StallF_o    = 1'b0;
        StallD_o    = 1'b0;
        StallE_o    = 1'b0;
        StallM_o    = 1'b0;
        FlushD_o    = 1'b0;
        FlushE_o    = 1'b0;
        FlushW_o    = 1'b0;

        unique case (state_q)
            RST_FLUSH: begin
                StallF_o  = 1'b1;
                FlushD_o  = 1'b1;
                FlushE_o  = 1'b1;
                FlushW_o  = 1'b1;
                tmo_cnt_d = '0;
                if (flush_cnt_q == '0) begin
                    state_d = RUN;
                end else begin
                    flush_cnt_d = flush_cnt_q - FCW'(1);
                end
            end

            RUN: begin
                if (DMemReqM_i && !DMemReadyM_i) begin
                    // Freeze: flush on D/E would override the hold, so only W is cleared
                    StallF_o  = 1'b1;
                    StallD_o  = 1'b1;
                    StallE_o  = 1'b1;
                    StallM_o  = 1'b1;
                    FlushW_o  = 1'b1;
                    tmo_cnt_d = '0;
                    state_d   = MEM_WAIT;
                end else begin
                    StallF_o = lw_stall;
                    StallD_o = lw_stall;
                    FlushD_o = PCSrcE_i;
                    FlushE_o = lw_stall | PCSrcE_i;
                end
            end

            MEM_WAIT: begin
                if (!DMemReadyM_i) begin
                    StallF_o  = 1'b1;
                    StallD_o  = 1'b1;
                    StallE_o  = 1'b1;
                    StallM_o  = 1'b1;
                    FlushW_o  = 1'b1;
                    tmo_cnt_d = tmo_inc;
                    if (tmo_inc == TMO_MAX) begin
                        mem_err_d = 1'b1;
                    end
                end else begin
                    // Release cycle: a branch held in E during the freeze flushes now
                    StallF_o = lw_stall;
                    StallD_o = lw_stall;
                    FlushD_o = PCSrcE_i;
                    FlushE_o = lw_stall | PCSrcE_i;
                    state_d  = RUN;
                end
            end

            default: begin
                state_d = RST_FLUSH;
            end
        endcase
    end

    // Controller state, purge counter, timeout counter and sticky error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RST_FLUSH;
            flush_cnt_q <= FLUSH_LOAD;
            tmo_cnt_q   <= '0;
            mem_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            tmo_cnt_q   <= tmo_cnt_d;
            mem_err_q   <= mem_err_d;
        end
    end

    assign MemErr_o = mem_err_q;

    forward_unit u_fwd_a (
        .RsE_i       (Rs1E_i),
        .RdM_i       (RdM_i),
        .RdW_i       (RdW_i),
        .RegWriteM_i (RegWriteM_i),
        .RegWriteW_i (RegWriteW_i),
        .Forward_o   (ForwardAE_o)
    );

    forward_unit u_fwd_b (
        .RsE_i       (Rs2E_i),
        .RdM_i       (RdM_i),
        .RdW_i       (RdW_i),
        .RegWriteM_i (RegWriteM_i),
        .RegWriteW_i (RegWriteW_i),
        .Forward_o   (ForwardBE_o)
    );

endmodule

// File: doc/hazard_ctrl_unit.md
# hazard_ctrl_unit

Central pipeline controller for the 5-stage RV32I core. Drives the stall (active-high hold) and flush (synchronous clear to NOP) inputs of the FD, DE, EM and MW pipeline registers. Generates the ALU operand forwarding selects. Sequences a post-reset pipeline purge and multi-cycle data-memory waits through a small FSM.

## Interface
Parameters:
- RESET_FLUSH_CYCLES, 2: cycles of forced purge after reset release, minimum 1.
- MEM_TIMEOUT, 255: MEM_WAIT cycles before MemErr_o is set, minimum 1.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- Rs1D_i, Rs2D_i  in  5  source registers in Decode.
- Rs1E_i, Rs2E_i, RdE_i  in  5  sources and destination in Execute.
- RdM_i, RdW_i  in  5  destinations in Memory and Writeback.
- RegWriteM_i, RegWriteW_i  in  1  register write enables in M and W.
- ResultSrcE0_i  in  1  instruction in E is a load.
- PCSrcE_i  in  1  branch or jump taken in E.
- DMemReqM_i  in  1  memory access in M.
- DMemReadyM_i  in  1  memory access completes this cycle.
- StallF_o, StallD_o, StallE_o, StallM_o  out  1  hold PC, FD, DE, EM.
- FlushD_o, FlushE_o, FlushW_o  out  1  clear FD, DE, MW to NOP.
- ForwardAE_o, ForwardBE_o  out  2  operand select: 00 register file, 01 W result, 10 M ALU result.
- MemErr_o  out  1  sticky timeout flag.

## Operation
- FSM states: RST_FLUSH, RUN, MEM_WAIT.
- RST_FLUSH: down-counter loaded with RESET_FLUSH_CYCLES-1 on reset.
  - Asserts StallF, FlushD, FlushE, FlushW.
  - Goes to RUN when the counter reaches 0.
- RUN:
  - If DMemReqM_i & ~DMemReadyM_i: freeze. StallF, StallD, StallE and StallM are 1. FlushW is 1 so W does not retire a duplicate. FlushD and FlushE are 0, because flush would override stall in the registers. Next state is MEM_WAIT and the timeout counter clears.
  - Otherwise, apply the hazard terms:
    - lwStall = ResultSrcE0_i & RdE_i≠0 & (RdE_i==Rs1D_i | RdE_i==Rs2D_i) & ~PCSrcE_i.
    - StallF = StallD = lwStall.
    - FlushD = PCSrcE_i.
    - FlushE = lwStall | PCSrcE_i.
    - FlushW, StallE and StallM are 0.
- MEM_WAIT:
  - Full freeze as above while ~DMemReadyM_i. The timeout counter increments, saturating.
  - MemErr_o sets when the count reaches MEM_TIMEOUT and stays set until reset. The freeze continues regardless.
  - When DMemReadyM_i=1, all freeze outputs drop in that same cycle and the RUN hazard terms apply in that cycle. Next state is RUN.
- Forwarding, in every state:
  - 10 if RegWriteM_i & RdM_i≠0 & RdM_i==Rs1E_i (resp. Rs2E_i).
  - Otherwise 01 if the same conditions hold with W.
  - Otherwise 00.
  - M has priority over W. x0 is never forwarded.
- Priority: RST_FLUSH > memory freeze > PCSrcE flush > load-use stall.
- A taken branch in E during a freeze is held by the frozen DE/EM registers. Its flush is issued in the release cycle.

## Timing
- Stall, flush and forward outputs are Mealy: combinational from the inputs and the registered state, valid in the same cycle.
- Reset values while rst_n=0:
  - State RST_FLUSH.
  - StallF, FlushD, FlushE, FlushW = 1.
  - StallD, StallE, StallM = 0.
  - MemErr_o = 0.
  - ForwardAE_o and ForwardBE_o combinational from the inputs.
- First RUN cycle is RESET_FLUSH_CYCLES edges after rst_n rises.
- Freeze latency: 0 cycles from DMemReqM_i & ~DMemReadyM_i. Release latency: 0 cycles from DMemReadyM_i.
- rst_n asserted mid-MEM_WAIT: state goes immediately to RST_FLUSH and MemErr_o clears.
- A single-cycle access (DMemReqM_i & DMemReadyM_i in RUN) causes no stall.

## Structure
- Package pipe_ctrl_pkg holds:
  - The state enum.
  - The forward-select constants FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10.
- Sub-module forward_unit: purely combinational, instantiated once per operand.

## Test plan
- Reset purge: release rst_n with RESET_FLUSH_CYCLES=2 -> StallF, FlushD, FlushE, FlushW = 1 for 2 cycles, then all 0 in RUN.
- Load-use: ResultSrcE0_i=1, RdE_i=5, Rs2D_i=5 -> StallF=StallD=FlushE=1 for one cycle. Repeat with RdE_i=0 -> no stall.
- Branch during load-use: PCSrcE_i=1 with lwStall conditions -> FlushD=FlushE=1, StallF=StallD=0.
- Memory wait: DMemReqM_i=1 with ready low for 3 cycles -> StallF, StallD, StallE, StallM and FlushW = 1 for exactly 3 cycles, all 0 in the ready cycle. Branch held in E -> FlushD=1 in the release cycle.
- Timeout: MEM_TIMEOUT=4 with ready never high -> MemErr_o=1 after 4 MEM_WAIT cycles and stays 1. rst_n pulse -> MemErr_o=0, state RST_FLUSH.
- Forwarding: RdM_i=RdW_i=Rs1E_i=7, both RegWrite=1 -> ForwardAE_o=10. RegWriteM_i=0 -> 01. Rs1E_i=0 -> 00.
